// File: rtl/clk_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider_prog
//  Description : Runtime-programmable integer clock divider. Produces a
//                one-cycle enable pulse (clk_flag) and a near-50% divided
//                level (clk_out) in the sys_clk domain. New divisors are
//                shadow-loaded and take effect only at a period boundary,
//                or on the next edge while counting is disabled.
//                Optional build macro DIV_PULSE_CNT_EN adds a 16-bit count
//                of emitted flags (pulse_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_divider_prog #(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_flag,
    output logic             clk_out,
    output logic [DIV_W-1:0] div_cur,
    output logic             load_err
`ifdef DIV_PULSE_CNT_EN
    ,
    output logic [15:0]      pulse_cnt
`endif
);

    localparam logic [DIV_W-1:0] c_div_default = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] c_one         = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_cur;
    logic [DIV_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_clk_flag;
    logic             r_clk_out;
    logic             r_load_err;

    logic             w_load_ok;
    logic             w_last;
    logic             w_apply;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W:0]   w_half;
    logic             w_out_nxt;
    logic             w_flag_nxt;

    // Next-state decode: apply/wrap/hold selection and look-ahead outputs so
    // clk_out and clk_flag are registered yet track the cnt held in the same cycle.
    always_comb begin
        w_load_ok  = div_load && (div_val > c_one);
        w_last     = (r_cnt == (r_div_cur - c_one));
        // Pending divisor takes over at the wrap, or immediately while idle.
        w_apply    = r_pend_vld && (!en || w_last);
        w_div_nxt  = r_div_cur;
        w_cnt_nxt  = r_cnt;
        if (w_apply) begin
            w_div_nxt = r_pend;
            w_cnt_nxt = '0;
        end else if (en) begin
            w_cnt_nxt = w_last ? '0 : (r_cnt + c_one);
        end
        // High phase starts at ceil(N/2); one extra bit avoids overflow at N=2^DIV_W-1.
        w_half     = ({1'b0, w_div_nxt} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        w_out_nxt  = ({1'b0, w_cnt_nxt} >= w_half);
        w_flag_nxt = en && (w_cnt_nxt == (w_div_nxt - c_one));
    end

    // Counter, divisor shadow register and output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt      <= '0;
            r_div_cur  <= c_div_default;
            r_pend     <= c_div_default;
            r_pend_vld <= 1'b0;
            r_clk_flag <= 1'b0;
            r_clk_out  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_div_cur  <= w_div_nxt;
            r_clk_flag <= w_flag_nxt;
            r_clk_out  <= w_out_nxt;
            r_load_err <= div_load && !w_load_ok;
            // A load on the apply edge becomes pending for the following boundary.
            if (w_load_ok) begin
                r_pend     <= div_val;
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign clk_flag = r_clk_flag;
    assign clk_out  = r_clk_out;
    assign div_cur  = r_div_cur;
    assign load_err = r_load_err;

`ifdef DIV_PULSE_CNT_EN
    logic [15:0] r_pulse_cnt;

    // Counts flag cycles; restarts whenever a new divisor is applied.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || w_apply) begin
            r_pulse_cnt <= '0;
        end else if (r_clk_flag) begin
            r_pulse_cnt <= r_pulse_cnt + 16'd1;
        end
    end

    assign pulse_cnt = r_pulse_cnt;
`endif

endmodule
`default_nettype wire
